// File: rtl/wb_if.sv
// wb_if: MEM/WB stage bus, upstream results in and register-file/PC control out.
interface wb_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int RWIDTH = 5,
  parameter int CWIDTH = 32
);
  logic              valid;
  logic              stall;
  logic              flush;
  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] alu_res;
  logic [DWIDTH-1:0] memory_data;
  logic [DWIDTH-1:0] imm;
  logic [1:0]        wbsel;
  logic [2:0]        funct3;
  logic              brtaken;
  logic [RWIDTH-1:0] rd;
  logic              regwren;
  logic              wb_valid;
  logic [DWIDTH-1:0] writeback_data;
  logic [RWIDTH-1:0] wb_rd;
  logic              wb_regwren;
  logic [AWIDTH-1:0] next_pc;
  logic              redirect;
  logic [CWIDTH-1:0] retired_cnt;
  modport master (
    output valid, stall, flush, pc, alu_res, memory_data, imm, wbsel, funct3, brtaken, rd, regwren,
    input  wb_valid, writeback_data, wb_rd, wb_regwren, next_pc, redirect, retired_cnt
  );
  modport slave (
    input  valid, stall, flush, pc, alu_res, memory_data, imm, wbsel, funct3, brtaken, rd, regwren,
    output wb_valid, writeback_data, wb_rd, wb_regwren, next_pc, redirect, retired_cnt
  );
endinterface

// File: rtl/writeback_pipe.sv
// writeback_pipe: registered MEM/WB stage with load alignment, write-back select, next-PC and retire counter.
module writeback_pipe #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int RWIDTH = 5,
  parameter int CWIDTH = 32
) (
  input logic clk,
  input logic reset,
  wb_if.slave bus
);
  logic              v, br, we;
  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] alu, mem, imm;
  logic [1:0]        ws;
  logic [2:0]        f3;
  logic [RWIDTH-1:0] rd;
  logic [CWIDTH-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v   <= 1'b0;
      br  <= 1'b0;
      we  <= 1'b0;
      pc  <= '0;
      alu <= '0;
      mem <= '0;
      imm <= '0;
      ws  <= '0;
      f3  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      v <= 1'b0;
    end else if (!bus.stall) begin
      v   <= bus.valid;
      br  <= bus.brtaken;
      we  <= bus.regwren;
      pc  <= bus.pc;
      alu <= bus.alu_res;
      mem <= bus.memory_data;
      imm <= bus.imm;
      ws  <= bus.wbsel;
      f3  <= bus.funct3;
      rd  <= bus.rd;
      cnt <= cnt + CWIDTH'(bus.valid);
    end
  logic [AWIDTH-1:0] pc4;
  logic [7:0]        bt;
  logic [15:0]       hw;
  logic [DWIDTH-1:0] ld, sel;
  always_comb begin
    pc4 = pc + AWIDTH'(4);
    bt  = mem[{alu[1:0], 3'b000} +: 8];
    hw  = alu[1] ? mem[31:16] : mem[15:0];
    ld  = f3 == 3'b000 ? {{24{bt[7]}}, bt} :
          f3 == 3'b001 ? {{16{hw[15]}}, hw} :
          f3 == 3'b100 ? {24'd0, bt} :
          f3 == 3'b101 ? {16'd0, hw} : mem;
    sel = ws == 2'd0 ? alu :
          ws == 2'd1 ? ld :
          ws == 2'd2 ? DWIDTH'(pc4) : imm;
  end
  assign bus.wb_valid       = v;
  assign bus.writeback_data = v ? sel : '0;
  assign bus.wb_rd          = rd;
  assign bus.wb_regwren     = v & we & (|rd);
  assign bus.next_pc        = v ? (br ? {alu[AWIDTH-1:1], 1'b0} : pc4) : '0;
  assign bus.redirect       = v & br;
  assign bus.retired_cnt    = cnt;
endmodule

// File: tb/tb_writeback_pipe.sv
// tb_writeback_pipe: directed and random stimulus against a behavioural model of the write-back stage.
module tb_writeback_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  wb_if #(.CWIDTH(4)) w ();
  writeback_pipe #(.CWIDTH(4)) dut (.clk(clk), .reset(reset), .bus(w.slave));
  always #5 clk = ~clk;
  bit          mv, mbr, mwe;
  logic [31:0] mpc, malu, mmem, mimm;
  int          mws, mf3, mrd, mcnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_data();
    int unsigned off, b, h;
    if (!mv) return 0;
    off = malu % 4;
    b = (mmem >> (8 * off)) & 32'hFF;
    h = (mmem >> (16 * (off / 2))) & 32'hFFFF;
    case (mws)
      0: return malu;
      2: return mpc + 32'd4;
      3: return mimm;
      default: case (mf3)
        0: return b >= 128 ? b - 256 : b;
        1: return h >= 32768 ? h - 65536 : h;
        4: return b;
        5: return h;
        default: return mmem;
      endcase
    endcase
  endfunction
  task automatic check_all();
    chk("valid", 32'(w.wb_valid), 32'(mv));
    chk("data", w.writeback_data, exp_data());
    if (mv) chk("rd", 32'(w.wb_rd), mrd);
    chk("regwren", 32'(w.wb_regwren), 32'(mv && mwe && mrd != 0));
    chk("next_pc", w.next_pc, !mv ? 0 : mbr ? (malu & ~32'd1) : mpc + 32'd4);
    chk("redirect", 32'(w.redirect), 32'(mv && mbr));
    chk("retired", 32'(w.retired_cnt), mcnt % 16);
  endtask
  task automatic model_reset();
    mv = 0; mbr = 0; mwe = 0; mpc = 0; malu = 0; mmem = 0; mimm = 0;
    mws = 0; mf3 = 0; mrd = 0; mcnt = 0;
  endtask
  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else if (w.flush) mv = 0;
    else if (!w.stall) begin
      mv = w.valid; mbr = w.brtaken; mwe = w.regwren; mpc = w.pc; malu = w.alu_res;
      mmem = w.memory_data; mimm = w.imm; mws = w.wbsel; mf3 = w.funct3; mrd = w.rd;
      if (w.valid) mcnt++;
    end
    #1;
    check_all();
  endtask
  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] imm, input logic [1:0] ws, input logic [2:0] f3,
                       input bit br, input logic [4:0] rd, input bit we);
    w.valid = v; w.pc = pc; w.alu_res = alu; w.memory_data = mem; w.imm = imm;
    w.wbsel = ws; w.funct3 = f3; w.brtaken = br; w.rd = rd; w.regwren = we;
    w.stall = 0; w.flush = 0;
  endtask
  task automatic rand_in();
    drive(1'($urandom), $urandom, $urandom, $urandom, $urandom, 2'($urandom), 3'($urandom),
          1'($urandom), 5'($urandom), 1'($urandom));
  endtask
  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    reset = 0;
    drive(1, 32'h100, 32'hDEAD, 0, 32'h7FF, 0, 3'd2, 0, 5, 1);
    cyc(); chk("sel_alu", w.writeback_data, 32'hDEAD); chk("regwren_on", 32'(w.wb_regwren), 1);
    w.wbsel = 3; cyc(); chk("sel_imm", w.writeback_data, 32'h7FF);
    w.wbsel = 2; cyc(); chk("sel_pc4", w.writeback_data, 32'h104); chk("cnt3", 32'(w.retired_cnt), 3);
    #2 reset = 1; #1;
    model_reset();
    check_all();
    chk("async_rst_valid", 32'(w.wb_valid), 0);
    cyc(); cyc();
    reset = 0;
    drive(1, 0, 0, 32'h80FF7F01, 0, 1, 3'b000, 0, 3, 1);
    for (int i = 0; i < 4; i++) begin
      w.alu_res = i;
      cyc();
      chk("lb", w.writeback_data, i == 0 ? 32'h01 : i == 1 ? 32'h7F : i == 2 ? 32'hFFFFFFFF : 32'hFFFFFF80);
    end
    w.funct3 = 3'b100; w.alu_res = 3; cyc(); chk("lbu3", w.writeback_data, 32'h80);
    w.funct3 = 3'b001; w.alu_res = 2; cyc(); chk("lh2", w.writeback_data, 32'hFFFF80FF);
    w.funct3 = 3'b101; w.alu_res = 0; cyc(); chk("lhu0", w.writeback_data, 32'h7F01);
    w.funct3 = 3'b010; w.alu_res = 1; cyc(); chk("lw", w.writeback_data, 32'h80FF7F01);
    drive(1, 32'h200, 32'h301, 0, 0, 0, 0, 1, 1, 0);
    cyc(); chk("br_pc", w.next_pc, 32'h300); chk("br_redir", 32'(w.redirect), 1);
    w.brtaken = 0;
    cyc(); chk("nbr_pc", w.next_pc, 32'h204); chk("nbr_redir", 32'(w.redirect), 0);
    drive(1, 32'h400, 32'h11, 0, 0, 0, 0, 0, 7, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      rand_in(); w.stall = 1;
      cyc(); chk("stall_hold", w.writeback_data, 32'h11); chk("stall_rd", 32'(w.wb_rd), 7);
    end
    w.flush = 1; w.stall = 1; w.valid = 1;
    cyc(); chk("flush_valid", 32'(w.wb_valid), 0); chk("flush_npc", w.next_pc, 0);
    chk("flush_we", 32'(w.wb_regwren), 0);
    drive(1, 32'h10, 32'h20, 0, 0, 0, 0, 0, 0, 1);
    cyc(); chk("x0_we", 32'(w.wb_regwren), 0);
    drive(1, 32'hFFFFFFFC, 0, 0, 0, 2, 0, 0, 1, 1);
    cyc(); chk("wrap_data", w.writeback_data, 0); chk("wrap_npc", w.next_pc, 0);
    reset = 1; cyc(); reset = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 17; i++) cyc();
    chk("cnt_wrap", 32'(w.retired_cnt), 1);
    for (int i = 0; i < 400; i++) begin
      rand_in();
      w.stall = ($urandom_range(0, 3) == 0);
      w.flush = ($urandom_range(0, 7) == 0);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
